// File: rtl/id_ex_decode_reg.sv
// ID/EX pipeline register with in-line decode of the D-stage instruction.
// Decode is purely combinational; the E-side outputs are one register stage
// that can be held (EX busy), loaded with a bubble (stall/flush), or loaded
// with the freshly decoded D-stage controls.
module id_ex_decode_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_d,
  input  logic [31:0] rs_data_d,
  input  logic [31:0] rt_data_d,
  input  logic        stall,
  input  logic        flush,
  input  logic        hold,
  output logic [2:0]  alu_ctr_e,
  output logic [31:0] alu_a_e,
  output logic [31:0] alu_b_e,
  output logic [31:0] rt_data_e,
  output logic [4:0]  wb_reg_e,
  output logic        reg_write_e,
  output logic        mem_write_e,
  output logic        mem_to_reg_e,
  output logic        link_e,
  output logic [31:0] pc8_e,
  output logic        valid_e,
  output logic        illegal_e
);

  // ALU operation encoding seen by the EX stage
  typedef enum logic [2:0] {
    ALU_ZERO   = 3'd0,
    ALU_ADD    = 3'd1,
    ALU_SUB    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_PASS_B = 3'd4
  } alu_op_t;

  // Primary opcodes
  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_J       = 6'h02,
    OP_JAL     = 6'h03,
    OP_BEQ     = 6'h04,
    OP_ORI     = 6'h0D,
    OP_LUI     = 6'h0F,
    OP_LW      = 6'h23,
    OP_SW      = 6'h2B
  } opcode_t;

  // SPECIAL funct codes
  typedef enum logic [5:0] {
    FN_JR   = 6'h08,
    FN_ADDU = 6'h21,
    FN_SUBU = 6'h23
  } funct_t;

  // Everything carried from D to E in one bundle
  typedef struct packed {
    alu_op_t     ctr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rt_data;
    logic [4:0]  wb;
    logic        rw;
    logic        mw;
    logic        m2r;
    logic        link;
    logic [31:0] pc8;
    logic        valid;
    logic        illegal;
  } ex_ctl_t;

  // Bubble and reset share one value: everything cleared except pc8
  function automatic ex_ctl_t bubble_ctl();
    ex_ctl_t c;
    c       = '0;
    c.ctr   = ALU_ZERO;
    c.pc8   = RESET_PC + 32'd8;
    return c;
  endfunction

  // Instruction fields
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt_f;
  logic [4:0]  rd_f;
  logic [15:0] imm;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] imm_lui;

  assign op       = instr_d[31:26];
  assign rt_f     = instr_d[20:16];
  assign rd_f     = instr_d[15:11];
  assign funct    = instr_d[5:0];
  assign imm      = instr_d[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};
  assign imm_lui  = {imm, 16'h0000};

  ex_ctl_t dec;
  logic    rw_raw;
  ex_ctl_t e_q;

  // Combinational decode of the D-stage instruction into E-stage controls
  always_comb begin
    dec         = '0;
    dec.ctr     = ALU_ZERO;
    dec.a       = rs_data_d;
    dec.b       = rt_data_d;
    dec.rt_data = rt_data_d;
    dec.pc8     = pc_d + 32'd8;
    dec.valid   = 1'b1;
    rw_raw      = 1'b0;

    case (op)
      OP_SPECIAL: begin
        if (instr_d == 32'h0000_0000) begin
          dec.ctr = ALU_ZERO;
        end else begin
          case (funct)
            FN_ADDU: begin
              dec.ctr = ALU_ADD;
              dec.wb  = rd_f;
              rw_raw  = 1'b1;
            end
            FN_SUBU: begin
              dec.ctr = ALU_SUB;
              dec.wb  = rd_f;
              rw_raw  = 1'b1;
            end
            FN_JR: begin
              dec.ctr = ALU_ZERO;
            end
            default: begin
              dec.illegal = 1'b1;
            end
          endcase
        end
      end
      OP_ORI: begin
        dec.ctr = ALU_OR;
        dec.b   = imm_zext;
        dec.wb  = rt_f;
        rw_raw  = 1'b1;
      end
      OP_LUI: begin
        dec.ctr = ALU_PASS_B;
        dec.b   = imm_lui;
        dec.wb  = rt_f;
        rw_raw  = 1'b1;
      end
      OP_LW: begin
        dec.ctr = ALU_ADD;
        dec.b   = imm_sext;
        dec.wb  = rt_f;
        dec.m2r = 1'b1;
        rw_raw  = 1'b1;
      end
      OP_SW: begin
        dec.ctr = ALU_ADD;
        dec.b   = imm_sext;
        dec.mw  = 1'b1;
      end
      OP_BEQ: begin
        dec.ctr = ALU_SUB;
      end
      OP_J: begin
        dec.ctr = ALU_ZERO;
      end
      OP_JAL: begin
        dec.ctr  = ALU_ZERO;
        dec.wb   = 5'd31;
        dec.link = 1'b1;
        rw_raw   = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase

    // Writes to $0 are suppressed here; wb keeps the decoded register number
    dec.rw = rw_raw & (dec.wb != 5'd0);
  end

  // ID/EX register: reset > hold > bubble (stall|flush) > load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= bubble_ctl();
    end else if (hold) begin
      e_q <= e_q;
    end else if (stall || flush) begin
      e_q <= bubble_ctl();
    end else begin
      e_q <= dec;
    end
  end

  assign alu_ctr_e    = e_q.ctr;
  assign alu_a_e      = e_q.a;
  assign alu_b_e      = e_q.b;
  assign rt_data_e    = e_q.rt_data;
  assign wb_reg_e     = e_q.wb;
  assign reg_write_e  = e_q.rw;
  assign mem_write_e  = e_q.mw;
  assign mem_to_reg_e = e_q.m2r;
  assign link_e       = e_q.link;
  assign pc8_e        = e_q.pc8;
  assign valid_e      = e_q.valid;
  assign illegal_e    = e_q.illegal;

endmodule

// File: tb/tb_id_ex_decode_reg.sv
// Directed bench for the ID/EX decode register: hand-computed vectors,
// bubble/hold interplay and asynchronous reset in the middle of a hold.
module tb_id_ex_decode_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_d = '0;
  logic [31:0] pc_d = '0;
  logic [31:0] rs_data_d = '0;
  logic [31:0] rt_data_d = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        hold = 1'b0;
  logic [2:0]  alu_ctr_e;
  logic [31:0] alu_a_e;
  logic [31:0] alu_b_e;
  logic [31:0] rt_data_e;
  logic [4:0]  wb_reg_e;
  logic        reg_write_e;
  logic        mem_write_e;
  logic        mem_to_reg_e;
  logic        link_e;
  logic [31:0] pc8_e;
  logic        valid_e;
  logic        illegal_e;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  id_ex_decode_reg #(.RESET_PC(32'h0000_3000)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_d      (instr_d),
    .pc_d         (pc_d),
    .rs_data_d    (rs_data_d),
    .rt_data_d    (rt_data_d),
    .stall        (stall),
    .flush        (flush),
    .hold         (hold),
    .alu_ctr_e    (alu_ctr_e),
    .alu_a_e      (alu_a_e),
    .alu_b_e      (alu_b_e),
    .rt_data_e    (rt_data_e),
    .wb_reg_e     (wb_reg_e),
    .reg_write_e  (reg_write_e),
    .mem_write_e  (mem_write_e),
    .mem_to_reg_e (mem_to_reg_e),
    .link_e       (link_e),
    .pc8_e        (pc8_e),
    .valid_e      (valid_e),
    .illegal_e    (illegal_e)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic expect_e(input string tag, input logic [2:0] ctr,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] rtd,
                          input logic [4:0] wb, input logic rw, input logic mw, input logic m2r,
                          input logic lk, input logic [31:0] pc8, input logic vld, input logic ill);
    check({tag, ".ctr"},   {29'd0, alu_ctr_e},    {29'd0, ctr});
    check({tag, ".a"},     alu_a_e,               a);
    check({tag, ".b"},     alu_b_e,               b);
    check({tag, ".rtd"},   rt_data_e,             rtd);
    check({tag, ".wb"},    {27'd0, wb_reg_e},     {27'd0, wb});
    check({tag, ".rw"},    {31'd0, reg_write_e},  {31'd0, rw});
    check({tag, ".mw"},    {31'd0, mem_write_e},  {31'd0, mw});
    check({tag, ".m2r"},   {31'd0, mem_to_reg_e}, {31'd0, m2r});
    check({tag, ".link"},  {31'd0, link_e},       {31'd0, lk});
    check({tag, ".pc8"},   pc8_e,                 pc8);
    check({tag, ".valid"}, {31'd0, valid_e},      {31'd0, vld});
    check({tag, ".ill"},   {31'd0, illegal_e},    {31'd0, ill});
  endtask

  task automatic expect_bubble(input string tag);
    expect_e(tag, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3008, 1'b0, 1'b0);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] rs, input logic [31:0] rt);
    instr_d   = ins;
    pc_d      = pc;
    rs_data_d = rs;
    rt_data_d = rt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held across the first edge
    step();
    expect_bubble("reset");
    reset = 1'b0;

    drive(32'h0022_1821, 32'h0000_3000, 32'd5, 32'd7);  // addu $3,$1,$2
    step();
    expect_e("addu", 3'd1, 32'd5, 32'd7, 32'd7, 5'd3, 1, 0, 0, 0, 32'h0000_3008, 1, 0);

    drive(32'h3C01_1234, 32'h0000_3004, 32'h11, 32'h22);  // lui $1
    step();
    expect_e("lui", 3'd4, 32'h11, 32'h1234_0000, 32'h22, 5'd1, 1, 0, 0, 0, 32'h0000_300C, 1, 0);

    drive(32'h3402_8000, 32'h0000_3008, 32'h33, 32'h44);  // ori $2,$0,0x8000
    step();
    expect_e("ori", 3'd3, 32'h33, 32'h0000_8000, 32'h44, 5'd2, 1, 0, 0, 0, 32'h0000_3010, 1, 0);

    drive(32'h8C85_FFFC, 32'h0000_300C, 32'h100, 32'h55);  // lw $5,-4($4)
    step();
    expect_e("lw", 3'd1, 32'h100, 32'hFFFF_FFFC, 32'h55, 5'd5, 1, 0, 1, 0, 32'h0000_3014, 1, 0);

    drive(32'hAC85_0010, 32'h0000_3010, 32'h200, 32'hDEAD);  // sw $5,16($4)
    step();
    expect_e("sw", 3'd1, 32'h200, 32'h10, 32'hDEAD, 5'd0, 0, 1, 0, 0, 32'h0000_3018, 1, 0);

    drive(32'h8C85_FFFC, 32'h0000_300C, 32'h100, 32'h55);
    stall = 1'b1;
    step();
    expect_bubble("stall");

    stall = 1'b0;
    step();
    expect_e("lw2", 3'd1, 32'h100, 32'hFFFF_FFFC, 32'h55, 5'd5, 1, 0, 1, 0, 32'h0000_3014, 1, 0);

    drive(32'h0022_1821, 32'h0000_3000, 32'd5, 32'd7);
    stall = 1'b1;
    hold  = 1'b1;
    step();
    expect_e("stall_hold", 3'd1, 32'h100, 32'hFFFF_FFFC, 32'h55, 5'd5, 1, 0, 1, 0, 32'h0000_3014, 1, 0);

    stall = 1'b0;
    drive(32'hAC85_0010, 32'h0000_3010, 32'h200, 32'hDEAD);
    step();
    expect_e("hold", 3'd1, 32'h100, 32'hFFFF_FFFC, 32'h55, 5'd5, 1, 0, 1, 0, 32'h0000_3014, 1, 0);

    hold  = 1'b0;
    flush = 1'b1;
    drive(32'h0022_1821, 32'h0000_3000, 32'd5, 32'd7);
    step();
    expect_bubble("flush");
    flush = 1'b0;

    drive(32'h0C00_0100, 32'hFFFF_FFFC, 32'd1, 32'd2);  // jal, pc8 wraps
    step();
    expect_e("jal", 3'd0, 32'd1, 32'd2, 32'd2, 5'd31, 1, 0, 0, 1, 32'h0000_0004, 1, 0);

    drive(32'hFC00_0000, 32'h0000_3020, 32'd3, 32'd4);  // op 3Fh
    step();
    expect_e("bad_op", 3'd0, 32'd3, 32'd4, 32'd4, 5'd0, 0, 0, 0, 0, 32'h0000_3028, 1, 1);

    drive(32'h0022_0021, 32'h0000_3024, 32'd5, 32'd7);  // addu $0 -> rw suppressed
    step();
    expect_e("addu_r0", 3'd1, 32'd5, 32'd7, 32'd7, 5'd0, 0, 0, 0, 0, 32'h0000_302C, 1, 0);

    drive(32'h0022_1823, 32'h0000_3028, 32'd9, 32'd4);  // subu $3
    step();
    expect_e("subu", 3'd2, 32'd9, 32'd4, 32'd4, 5'd3, 1, 0, 0, 0, 32'h0000_3030, 1, 0);

    drive(32'h1022_0005, 32'h0000_302C, 32'd6, 32'd6);  // beq
    step();
    expect_e("beq", 3'd2, 32'd6, 32'd6, 32'd6, 5'd0, 0, 0, 0, 0, 32'h0000_3034, 1, 0);

    drive(32'h0000_0000, 32'h0000_3030, 32'd0, 32'd0);  // nop
    step();
    expect_e("nop", 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 32'h0000_3038, 1, 0);

    drive(32'h03E0_0008, 32'h0000_3034, 32'h400, 32'd0);  // jr $31
    step();
    expect_e("jr", 3'd0, 32'h400, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 32'h0000_303C, 1, 0);

    drive(32'h0022_182A, 32'h0000_3038, 32'd1, 32'd2);  // slt: unsupported funct
    step();
    expect_e("bad_fn", 3'd0, 32'd1, 32'd2, 32'd2, 5'd0, 0, 0, 0, 0, 32'h0000_3040, 1, 1);

    drive(32'h0800_0010, 32'h0000_303C, 32'd7, 32'd8);  // j
    step();
    expect_e("j", 3'd0, 32'd7, 32'd8, 32'd8, 5'd0, 0, 0, 0, 0, 32'h0000_3044, 1, 0);

    // asynchronous reset while holding, between edges
    hold = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    expect_bubble("async_rst");
    step();
    expect_bubble("rst_hold");

    reset = 1'b0;
    hold  = 1'b0;
    drive(32'h0022_1821, 32'h0000_3000, 32'd5, 32'd7);
    step();
    expect_e("post_rst", 3'd1, 32'd5, 32'd7, 32'd7, 5'd3, 1, 0, 0, 0, 32'h0000_3008, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
